// File: rtl/tempsens_pkg.sv
// tempsens_pkg: shared widths, FSM encoding and window-length helper for the
// temperature-sensor averaging filter.
//   N_TEMP       : width of results, averages, min/max and thresholds
//   LOG2_AVG_MAX : largest supported log2 window length
//   ACC_W        : accumulator width (cannot overflow for 2^LOG2_AVG_MAX samples)
//   K_W          : width of a latched log2 window length
//   CNT_W        : width of the in-window sample counter
package tempsens_pkg;

  localparam int N_TEMP       = 20;
  localparam int LOG2_AVG_MAX = 3;
  localparam int ACC_W        = N_TEMP + LOG2_AVG_MAX;
  localparam int K_W          = $clog2(LOG2_AVG_MAX + 1);
  localparam int CNT_W        = LOG2_AVG_MAX;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Limit a requested log2 window length to the supported maximum.
  function automatic logic [K_W-1:0] clamp_k(input logic [1:0] req);
    int unsigned req_i;
    req_i = {30'd0, req};
    if (req_i > LOG2_AVG_MAX) begin
      return K_W'(LOG2_AVG_MAX);
    end
    return K_W'(req_i);
  endfunction

endpackage

// File: rtl/tempsens_accum.sv
// tempsens_accum: boxcar accumulator for the temperature filter.
// Holds the running sum, the sample counter and the window length latched on
// the first sample of each window; flags the last sample of a window.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_en           : enable; low clears any window in progress
//   i_res          : conversion result
//   i_res_valid    : one-cycle strobe marking a new result
//   i_avg_log2     : requested log2 window length (clamped)
//   o_sum          : running sum including the current sample (combinational)
//   o_k            : log2 window length that applies to the current sample
//   o_done         : high in the cycle the last sample of a window is taken
//   o_state        : FSM state, for debug/observation
module tempsens_accum
  import tempsens_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic [N_TEMP-1:0] i_res,
  input  logic              i_res_valid,
  input  logic [1:0]        i_avg_log2,
  output logic [ACC_W-1:0]  o_sum,
  output logic [K_W-1:0]    o_k,
  output logic              o_done,
  output state_e            o_state
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [K_W-1:0]     r_k;

  logic [K_W-1:0]     w_k_req;
  logic [K_W-1:0]     w_k_eff;
  logic [CNT_W:0]     w_len;
  logic [CNT_W:0]     w_len_m1;
  logic               w_take;
  logic               w_last;
  logic [ACC_W-1:0]   w_sum;

  assign w_k_req = clamp_k(i_avg_log2);
  // The first sample of a window decides its length, so it must already use
  // the freshly requested value rather than the stale latch.
  assign w_k_eff  = (r_cnt == '0) ? w_k_req : r_k;
  assign w_len    = (CNT_W+1)'(1) << w_k_eff;
  assign w_len_m1 = w_len - (CNT_W+1)'(1);
  assign w_last   = (r_cnt == w_len_m1[CNT_W-1:0]);
  // A strobe counts only once the FSM has seen enable for a full cycle.
  assign w_take   = (r_state == ST_ACCUM) && i_en && i_res_valid;
  assign w_sum    = r_acc + {{LOG2_AVG_MAX{1'b0}}, i_res};

  assign o_sum   = w_sum;
  assign o_k     = w_k_eff;
  assign o_done  = w_take && w_last;
  assign o_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_en)  w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (!i_en) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!i_en) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_take) begin
        if (r_cnt == '0) begin
          r_k <= w_k_req;
        end
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tempsens_filter.sv
// tempsens_filter: averages 2^k conversion results and presents each average
// through a valid/ready handshake, tracking min/max and a hysteretic alarm.
// Handshake: o_avg transfers on any clock edge where o_avg_valid and
// i_avg_ready are both high; o_avg is held stable while valid and not taken;
// a new average arriving while the held one is not taken overwrites it and
// sets the sticky o_ovf.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   i_en                : enable; low aborts the window in progress
//   i_res, i_res_valid  : conversion result and its one-cycle strobe
//   i_avg_log2          : requested log2 window length
//   i_thr_hi, i_thr_lo  : alarm set / clear thresholds
//   i_clr_flags         : clears o_ovf, o_min, o_max
//   o_avg, o_avg_valid  : average and its valid flag; i_avg_ready accepts it
//   o_min, o_max        : extremes of the averages since reset/clear
//   o_alarm, o_ovf      : hysteretic alarm, sticky overwrite flag
//   o_dbg_state         : accumulator FSM state
module tempsens_filter
  import tempsens_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic [N_TEMP-1:0] i_res,
  input  logic              i_res_valid,
  input  logic [1:0]        i_avg_log2,
  input  logic [N_TEMP-1:0] i_thr_hi,
  input  logic [N_TEMP-1:0] i_thr_lo,
  input  logic              i_clr_flags,
  output logic [N_TEMP-1:0] o_avg,
  output logic              o_avg_valid,
  input  logic              i_avg_ready,
  output logic [N_TEMP-1:0] o_min,
  output logic [N_TEMP-1:0] o_max,
  output logic              o_alarm,
  output logic              o_ovf,
  output state_e            o_dbg_state
);

  logic [ACC_W-1:0]  w_sum;
  logic [K_W-1:0]    w_k;
  logic              w_load;
  logic [ACC_W-1:0]  w_shift;
  logic [N_TEMP-1:0] w_new_avg;
  logic              w_overwrite;

  logic [N_TEMP-1:0] r_avg;
  logic              r_avg_valid;
  logic [N_TEMP-1:0] r_min;
  logic [N_TEMP-1:0] r_max;
  logic              r_alarm;
  logic              r_ovf;

  tempsens_accum u_accum (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_en        (i_en),
    .i_res       (i_res),
    .i_res_valid (i_res_valid),
    .i_avg_log2  (i_avg_log2),
    .o_sum       (w_sum),
    .o_k         (w_k),
    .o_done      (w_load),
    .o_state     (o_dbg_state)
  );

  // Dividing by 2^k truncates; the sum of 2^k N_TEMP-bit values shifted by k
  // always fits back into N_TEMP bits.
  assign w_shift     = w_sum >> w_k;
  assign w_new_avg   = w_shift[N_TEMP-1:0];
  assign w_overwrite = w_load && r_avg_valid && !i_avg_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_min       <= '1;
      r_max       <= '0;
      r_alarm     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_avg       <= w_new_avg;
        r_avg_valid <= 1'b1;
      end else if (r_avg_valid && i_avg_ready) begin
        r_avg_valid <= 1'b0;
      end

      if (i_clr_flags) begin
        r_ovf <= w_overwrite;
        r_min <= w_load ? w_new_avg : '1;
        r_max <= w_load ? w_new_avg : '0;
      end else begin
        if (w_overwrite) begin
          r_ovf <= 1'b1;
        end
        if (w_load && (w_new_avg < r_min)) begin
          r_min <= w_new_avg;
        end
        if (w_load && (w_new_avg > r_max)) begin
          r_max <= w_new_avg;
        end
      end

      // Set is tested first so it wins when the thresholds are inverted.
      if (w_load) begin
        if (w_new_avg > i_thr_hi) begin
          r_alarm <= 1'b1;
        end else if (w_new_avg < i_thr_lo) begin
          r_alarm <= 1'b0;
        end
      end
    end
  end

  assign o_avg       = r_avg;
  assign o_avg_valid = r_avg_valid;
  assign o_min       = r_min;
  assign o_max       = r_max;
  assign o_alarm     = r_alarm;
  assign o_ovf       = r_ovf;

endmodule

// File: doc/tempsens_filter.md
Name: tempsens_filter

Overview:
- Downstream of the temperature-sensor top.
- Consumes each new 20-bit conversion result and averages a power-of-two number of samples in a boxcar window.
- Presents each average through a valid/ready handshake.
- Tracks min/max of the averages and raises a hysteretic over-threshold alarm for the debug/readout path.

Parameters:
- N_TEMP, 20, width of incoming result and of all average/min/max/threshold values.
- LOG2_AVG_MAX, 3, maximum log2 of window length (max 8 samples); accumulator width N_TEMP+LOG2_AVG_MAX.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_en  in  1  filter enable; low clears the window in progress.
- i_res  in  N_TEMP  conversion result from the sensor top.
- i_res_valid  in  1  one-cycle strobe, high in the cycle i_res holds a newly updated result.
- i_avg_log2  in  2  requested log2 of window length; values >LOG2_AVG_MAX clamp to LOG2_AVG_MAX.
- i_thr_hi  in  N_TEMP  alarm set threshold.
- i_thr_lo  in  N_TEMP  alarm clear threshold.
- i_clr_flags  in  1  synchronous clear of o_ovf, o_min and o_max.
- o_avg  out  N_TEMP  averaged result.
- o_avg_valid  out  1  o_avg holds an untransferred average.
- i_avg_ready  in  1  consumer accepts o_avg.
- o_min  out  N_TEMP  smallest average since reset/clear.
- o_max  out  N_TEMP  largest average since reset/clear.
- o_alarm  out  1  hysteretic threshold alarm.
- o_ovf  out  1  sticky: an unconsumed average was overwritten.

Behaviour:
- Reset (reset_n low, async): acc=0, cnt=0, o_avg=0, o_avg_valid=0, o_min=all ones, o_max=0, o_alarm=0, o_ovf=0, latched window length=0.
- Reset mid-window discards partial sums; no average is produced.
- States:
  - IDLE: i_en=0. acc and cnt held at 0; strobes are ignored; output register, handshake and flags are unaffected.
  - ACCUM: i_en=1. Entered the cycle after i_en rises.
- Window length L=2^k. k is latched from clamped i_avg_log2 on the first strobe of each window (cnt==0). Changes mid-window take effect on the next window.
- Each strobe in ACCUM: acc += zero-extended i_res; cnt++.
- On the strobe where cnt==L-1 (last sample):
  - Next cycle: o_avg = (acc+i_res)>>k (truncating), o_avg_valid=1.
  - acc and cnt are cleared in that same edge.
  - Latency: one clock from the last strobe to o_avg_valid.
  - k=0 passes each sample through with one cycle latency.
- i_en falling mid-window: acc and cnt clear at the next edge; no partial average is produced.
- Handshake:
  - Transfer occurs on any edge with o_avg_valid & i_avg_ready.
  - o_avg is stable while o_avg_valid=1 and no transfer occurs.
  - o_avg_valid drops after a transfer unless a new average loads in the same cycle.
  - New average while valid & !ready: o_avg is overwritten, valid stays 1, o_ovf is set.
  - New average while valid & ready: old value transfers, new value loads, valid stays 1, o_ovf is not set.
- Min/max/alarm are updated in the same edge that loads a new average, using the new value.
  - o_min = min(o_min, avg); o_max = max(o_max, avg), unsigned compare.
  - o_alarm sets when avg > i_thr_hi and clears when avg < i_thr_lo; otherwise it holds.
  - If i_thr_lo > i_thr_hi, set has priority.
- i_clr_flags:
  - Without a new average in the same cycle: o_ovf=0, o_min=all ones, o_max=0.
  - With a new average in the same cycle: o_min=o_max=new avg, and o_ovf=1 if this cycle overwrites, else 0.
  - Does not affect o_alarm or o_avg.
- Accumulator never overflows (width N_TEMP+LOG2_AVG_MAX).
- All-ones inputs for L=8 yield o_avg=all ones.

Decomposition:
- Package tempsens_pkg: N_TEMP, LOG2_AVG_MAX, and the state encoding (ST_IDLE, ST_ACCUM).
- One sub-module tempsens_accum: accumulator, sample counter, window-length latch and last-sample detect; outputs the sum and a done strobe.
- Handshake, min/max and alarm stay in tempsens_filter.

Test Plan:
- k=2, i_en=1, strobes with i_res=100,101,102,103 -> o_avg=101, o_avg_valid high one cycle after the 4th strobe; with i_avg_ready=1 it drops the following cycle.
- k=0, i_avg_ready=0, two strobes 500 then 600 -> o_avg=600, o_avg_valid=1, o_ovf=1; then i_clr_flags -> o_ovf=0, o_min=all ones, o_max=0.
- k=3, i_en dropped after 5 strobes, re-enabled, then 8 strobes of 40 -> single average 40; no output from the aborted window.
- i_thr_hi=1000, i_thr_lo=900, k=0 samples 950, 1001, 950, 899, 950 -> o_alarm 0, 1, 1, 0, 0; o_min=899, o_max=1001.
- reset_n pulsed low mid-window (3 of 8 samples taken) -> all outputs at reset values immediately; next full window averages only post-reset samples.
- i_avg_log2 changed 3->1 after the 2nd strobe of an 8-sample window -> current window still completes at 8 samples; the next window uses 2.
